efpga_config_loader: RTL
========================

// Module: efpga_config_loader
// PURPOSE
//  Wishbone-slave bitstream loader for the eFPGA fabric inside the user project wrapper. Firmware pushes
//  32-bit configuration words into a FIFO. A sequencer assembles them into frames of FRAME_WORDS words.
//  It writes each frame to the fabric config port in order (addr 0..NUM_FRAMES-1), then flags done/irq.
// PARAMETERS
//  FRAME_WORDS  2   32-bit words per frame; cfg_frame_data width = 32*FRAME_WORDS
//  NUM_FRAMES   20  frames per full bitstream
//  FIFO_DEPTH   8   word FIFO entries, power of 2
//  FA_W         5   cfg_frame_addr width; must satisfy 2**FA_W >= NUM_FRAMES
// PORTS
//  wb_clk_i          in   1      sole clock
//  wb_rst_i          in   1      synchronous, active-high reset
//  wbs_stb_i         in   1      WB strobe
//  wbs_cyc_i         in   1      WB cycle
//  wbs_we_i          in   1      WB write enable
//  wbs_sel_i         in   4      byte selects; any partial write to DATA pushes the full word
//  wbs_adr_i         in   32     only bits [3:2] decoded
//  wbs_dat_i         in   32     write data
//  wbs_ack_o         out  1      single-cycle ack
//  wbs_dat_o         out  32     read data, valid while ack is high
//  cfg_frame_data    out  32*FW  assembled frame, word0 in LSBs
//  cfg_frame_addr    out  FA_W   target frame index
//  cfg_frame_we      out  1      1-cycle frame write strobe
//  cfg_busy          out  1      high while loading; fabric user logic is held inactive
//  cfg_done_irq      out  1      1-cycle pulse when last frame is written
// BEHAVIOUR
//  Registers (adr[3:2]): 0 CTRL W, bit0=start, bit1=abort, both self-clearing; reads return 0.
//   1 STATUS R: {16'b0, level[7:0], 5'b0, err, done, busy}.
//   2 DATA W: push word; reads return 0. 3 FRAME R: current frame index, zero-extended.
//  WB: ack rises the cycle after stb&cyc&!ack; there are no wait states.
//   Back-to-back requests give ack on every other cycle. A write takes effect on the ack cycle.
//  Reset: all outputs 0, FIFO empty, state IDLE, err=done=0, frame idx=0.
//  FSM:
//   IDLE -> FILL on start.
//   FILL pops one word per cycle while the FIFO is non-empty and shifts it into word slot wcnt.
//    After FRAME_WORDS words it goes to STROBE.
//   STROBE asserts cfg_frame_we for exactly 1 cycle; data and addr are stable in that cycle.
//    If idx==NUM_FRAMES-1, go to DONE. Otherwise idx++, wcnt=0, go to FILL.
//   DONE pulses cfg_done_irq for 1 cycle, sets sticky done, goes to IDLE, and clears idx to 0.
//  cfg_busy = (state != IDLE).
//  FIFO empty in FILL: stall, with no timeout.
//  Push while full: word dropped, err set (sticky).
//   A push and a pop in the same cycle while full is accepted, with no err.
//  start while busy: ignored. start from IDLE clears done and err.
//  abort (any state): next cycle IDLE, FIFO flushed, idx=wcnt=0, no we/irq.
//   abort and start in the same write: abort wins.
//  DATA writes in IDLE are accepted; this is the pre-fill path.
//  Reset mid-load is equivalent to abort and also clears err/done.
//  Counters: wcnt is clog2(FRAME_WORDS) bits; idx is FA_W bits. Neither wraps; both are cleared explicitly.
// STRUCTURE
//  Include efpga_cfg_defs.vh holds register offsets, CTRL/STATUS bit positions, and state encodings.
//  The state encodings are IDLE, FILL, STROBE, DONE.
//  Sub-module cfg_word_fifo is a synchronous FIFO.
//   Ports: push, pop, din, dout, full, empty, level, flush. Show-ahead read.
//  The top level contains the WB decode, the FSM, the frame shift register and the counters.
// TESTING
//  T1 Reset, then read STATUS -> 0x0000_0000. Read FRAME -> 0.
//  T2 FW=2, NF=20. Pre-fill 8 words, start, and stream 32 more words.
//   -> exactly 20 we pulses, addr 0..19, each frame matching {w[2k+1],w[2k]}.
//   -> one irq pulse; STATUS=0x2.
//  T3 Push 9 words while IDLE (depth 8) -> STATUS=0x0804; the 9th word is absent from frame data.
//  T4 Start with an empty FIFO -> busy=1 and no we. Push 1 word -> still no we.
//   Push a 2nd word -> we for frame 0 follows within 3 cycles.
//  T5 Abort after frame 5 is written -> next cycle busy=0, level=0, FRAME=0, no irq.
//   A new start plus 40 words gives a clean full load.
//  T6 Assert wb_rst_i mid-FILL -> all outputs 0 on the next edge. Write start+abort together -> remains IDLE.

Source files
------------

// File: rtl/efpga_config_loader_pkg.sv
// Register map, control/status bit positions and sequencer states shared by the
// eFPGA bitstream loader.
package efpga_config_loader_pkg;

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegData   = 2'd2;
    localparam logic [1:0] RegFrame  = 2'd3;

    localparam int unsigned CtrlStartBit   = 0;
    localparam int unsigned CtrlAbortBit   = 1;

    localparam int unsigned StatusBusyBit  = 0;
    localparam int unsigned StatusDoneBit  = 1;
    localparam int unsigned StatusErrBit   = 2;
    localparam int unsigned StatusLevelLsb = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStrobe,
        StDone
    } load_state_e;

endpackage

// File: rtl/cfg_word_fifo.sv
// Synchronous show-ahead word FIFO. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; flush empties it immediately.
module cfg_word_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_q];
    assign level   = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/efpga_config_loader.sv
// Wishbone-slave bitstream loader: buffers firmware words, assembles them into frames
// and writes frames 0..NUM_FRAMES-1 to the fabric config port.
module efpga_config_loader
    import efpga_config_loader_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 2,
    parameter int unsigned NUM_FRAMES  = 20,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FA_W        = 5
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [32*FRAME_WORDS-1:0] cfg_frame_data,
    output logic [FA_W-1:0]           cfg_frame_addr,
    output logic                      cfg_frame_we,
    output logic                      cfg_busy,
    output logic                      cfg_done_irq
);

    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned FD_W   = 32 * FRAME_WORDS;

    logic              ack_q;
    logic              req_we_q;
    logic [1:0]        req_adr_q;
    logic [31:0]       req_dat_q;
    logic              new_req;
    logic              wr_ctrl;
    logic              start_req;
    logic              abort_req;
    logic              push_req;

    load_state_e       state_q, state_d;
    logic [FA_W-1:0]   idx_q, idx_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [FD_W-1:0]   frame_q, frame_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fifo_pop;
    logic              fifo_flush;
    logic [31:0]       fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    // Only adr[3:2] is decoded; byte selects never narrow a DATA push.
    logic unused_wb;
    assign unused_wb = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    assign new_req   = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr_ctrl   = ack_q & req_we_q & (req_adr_q == RegCtrl);
    assign abort_req = wr_ctrl & req_dat_q[CtrlAbortBit];
    assign start_req = wr_ctrl & req_dat_q[CtrlStartBit] & ~req_dat_q[CtrlAbortBit];
    assign push_req  = ack_q & req_we_q & (req_adr_q == RegData);

    cfg_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push_req),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (req_dat_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wcnt_d       = wcnt_q;
        frame_d      = frame_q;
        done_d       = done_q;
        err_d        = err_q;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        cfg_frame_we = 1'b0;
        cfg_done_irq = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    state_d = StFill;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StFill: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    for (int unsigned i = 0; i < FRAME_WORDS; i++) begin
                        if (wcnt_q == WCNT_W'(i)) frame_d[32*i +: 32] = fifo_dout;
                    end
                    if (wcnt_q == WCNT_W'(FRAME_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = StStrobe;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            StStrobe: begin
                cfg_frame_we = 1'b1;
                wcnt_d       = '0;
                if (idx_q == FA_W'(NUM_FRAMES - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + FA_W'(1);
                    state_d = StFill;
                end
            end
            StDone: begin
                cfg_done_irq = 1'b1;
                done_d       = 1'b1;
                idx_d        = '0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A same-cycle pop frees the slot, so only an unmatched push into a full FIFO drops.
        if (push_req && fifo_full && !fifo_pop) err_d = 1'b1;

        if (abort_req) begin
            state_d      = StIdle;
            idx_d        = '0;
            wcnt_d       = '0;
            done_d       = done_q;
            fifo_flush   = 1'b1;
            fifo_pop     = 1'b0;
            cfg_frame_we = 1'b0;
            cfg_done_irq = 1'b0;
        end
    end

    always_comb begin
        wbs_dat_o = '0;
        if (ack_q && !req_we_q) begin
            unique case (req_adr_q)
                RegStatus: begin
                    wbs_dat_o[StatusBusyBit]          = cfg_busy;
                    wbs_dat_o[StatusDoneBit]          = done_q;
                    wbs_dat_o[StatusErrBit]           = err_q;
                    wbs_dat_o[StatusLevelLsb +: 8]    = 8'(fifo_level);
                end
                RegFrame: wbs_dat_o = 32'(idx_q);
                default:  wbs_dat_o = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            req_we_q  <= 1'b0;
            req_adr_q <= RegCtrl;
            req_dat_q <= '0;
            state_q   <= StIdle;
            idx_q     <= '0;
            wcnt_q    <= '0;
            frame_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= new_req;
            if (new_req) begin
                req_we_q  <= wbs_we_i;
                req_adr_q <= wbs_adr_i[3:2];
                req_dat_q <= wbs_dat_i;
            end
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wbs_ack_o      = ack_q;
    assign cfg_busy       = (state_q != StIdle);
    assign cfg_frame_data = frame_q;
    assign cfg_frame_addr = idx_q;

endmodule
